// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant ids and the
// counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Width of the access countdown; never narrower than one bit so a
    // single-cycle memory still has a legal counter.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester, memory and status signals around the arbiter.
//
// Handshake: each requester raises req with address/data and holds all of
// them stable until its ready pulses for one cycle; ready doubles as the
// rdata-valid strobe. The requester may drop or change req in the cycle after
// ready. There is no backpressure on ready.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_port_arbiter_pkg::*;

    logic              halt;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    arb_state_t        state;      // debug view of the arbiter FSM

    modport slave (
        input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, state
    );

    modport master (
        output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, state
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational; the last_grant history
// flop lives in the parent so it only moves on an actual grant.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,         // bit 0 = fetch, bit 1 = data
    input  grant_t     last_grant,
    output grant_t     grant,
    output logic       valid
);

    // A lone requester wins; on a tie the one not served last wins.
    always_comb begin
        valid = |req;
        grant = GNT_FETCH;
        case (req)
            2'b01:   grant = GNT_FETCH;
            2'b10:   grant = GNT_DATA;
            2'b11:   grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
            default: grant = GNT_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported main memory between instruction fetch and the
// load/store stage. One access at a time: IDLE grants, ACCESS drives the
// memory for MEM_LATENCY cycles, DONE pulses the winner's ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int             CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    grant_t            last_grant_q;
    grant_t            gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    grant_t            arb_grant;
    logic              arb_valid;
    logic              grant_fire;
    logic              last_beat;

    rr_arbiter2 u_rr (
        .req        ({bus.d_req, bus.if_req}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Final ACCESS cycle: memory read data is valid now.
    assign last_beat = (state_q == ACCESS) && (cnt_q == '0);

    // Next-state decode; requests are only looked at in IDLE, so DONE
    // cannot re-serve a requester that is still holding req high.
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.halt && arb_valid) begin
                    state_d    = ACCESS;
                    grant_fire = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's request on grant and count the access down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= GNT_FETCH;
            gnt_q        <= GNT_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant_fire) begin
            gnt_q        <= arb_grant;
            last_grant_q <= arb_grant;
            cnt_q        <= CNT_LOAD;
            if (arb_grant == GNT_DATA) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
            end
        end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Capture read data into the granted requester's register; stores leave
    // both untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (last_beat && !we_q) begin
            if (gnt_q == GNT_FETCH) begin
                if_rdata_q <= bus.mem_rdata;
            end else begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Outputs decode from state and registers only.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ready  = (state_q == DONE) && (gnt_q == GNT_FETCH);
    assign bus.d_ready   = (state_q == DONE) && (gnt_q == GNT_DATA);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;

endmodule
